// File: rtl/logic_gate_array_pkg.sv
// lga_pkg: shared types and helpers for logic_gate_array.
//   lga_op_e    - 3-bit operation code carried on in_op
//   lga_state_e - burst FSM state
//   lga_eval()  - evaluates the single-beat gate ops (0-5) on up to 64 bits
//   lga_is_acc()- true for the two accumulate ops
package lga_pkg;

  typedef enum logic [2:0] {
    LGA_NOT     = 3'd0,
    LGA_AND     = 3'd1,
    LGA_OR      = 3'd2,
    LGA_NAND    = 3'd3,
    LGA_NOR     = 3'd4,
    LGA_XOR     = 3'd5,
    LGA_ACC_AND = 3'd6,
    LGA_ACC_OR  = 3'd7
  } lga_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } lga_state_e;

  localparam int LGA_MAX_W = 64;

  // Operands are zero-extended to 64 bits by the caller; the caller truncates
  // the result back, so the inverted upper bits never reach the output.
  function automatic logic [LGA_MAX_W-1:0] lga_eval(input lga_op_e op,
                                                    input logic [LGA_MAX_W-1:0] a,
                                                    input logic [LGA_MAX_W-1:0] b);
    logic [LGA_MAX_W-1:0] r;
    case (op)
      LGA_NOT:  r = ~a;
      LGA_AND:  r = a & b;
      LGA_OR:   r = a | b;
      LGA_NAND: r = ~(a & b);
      LGA_NOR:  r = ~(a | b);
      LGA_XOR:  r = a ^ b;
      default:  r = a;
    endcase
    return r;
  endfunction

  function automatic logic lga_is_acc(input lga_op_e op);
    return (op == LGA_ACC_AND) || (op == LGA_ACC_OR);
  endfunction

endpackage

// File: rtl/logic_gate_array_if.sv
// logic_gate_array_if: operand/result handshake bundle for logic_gate_array.
//   in_*  : operand beat channel (valid/ready, op, A, B, last)
//   out_* : result channel (valid/ready, data, beat count, optional reductions)
//   master modport drives beats and accepts results; slave is the datapath.
// Optional feature macro: LGA_REDUCE_EN adds out_red.
interface logic_gate_array_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
`ifdef LGA_REDUCE_EN
  logic [2:0]       out_red;
`endif

  modport master (
`ifdef LGA_REDUCE_EN
    input  out_red,
`endif
    output in_valid, in_op, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
`ifdef LGA_REDUCE_EN
    output out_red,
`endif
    input  in_valid, in_op, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/logic_gate_array_out_reg.sv
// lga_out_reg: result holding register with valid/ready semantics.
//   clk, reset      - clock, synchronous active-high reset
//   load_i          - a new result is presented this cycle
//   load_data_i     - result value, load_count_i - beats folded into it
//   out_ready_i     - downstream accepts the held result
//   out_valid_o/out_data_o/out_count_o - registered result
//   out_red_o       - {^,|,&} of the result (only with LGA_REDUCE_EN)
// Upstream only loads when the register is empty or being drained, so a
// load never overwrites a result that is still being held.
module lga_out_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [CNT_W-1:0] load_count_i,
  input  logic             out_ready_i,
`ifdef LGA_REDUCE_EN
  output logic [2:0]       out_red_o,
`endif
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] out_count_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      // covers the same-cycle drain-and-refill case without a bubble
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      count_q <= load_count_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end
  end

`ifdef LGA_REDUCE_EN
  logic [2:0] red_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q <= 3'b000;
    end else if (load_i) begin
      red_q <= {^load_data_i, |load_data_i, &load_data_i};
    end else if (out_ready_i) begin
      red_q <= 3'b000;
    end
  end

  assign out_red_o = red_q;
`endif

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_count_o = count_q;

endmodule

// File: rtl/logic_gate_array.sv
// logic_gate_array: bitwise gate datapath with burst accumulate.
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - logic_gate_array_if.slave (operand beats in, results out)
// Ops 0-5 give one result per beat; ops 6/7 fold in_a over a burst closed
// by in_last. Optional feature macro: LGA_REDUCE_EN (adds bus.out_red).
//
// state    | meaning
// ST_IDLE  | no burst open; next beat decides op
// ST_ACCUM | burst open; acc/cnt hold the partial fold, op latched
module logic_gate_array
  import lga_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  logic_gate_array_if.slave   bus
);

  lga_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_or_q;

  lga_op_e          op;
  logic             accept;
  logic             in_ready;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_next;
  logic             load_d;
  logic [WIDTH-1:0] load_data_d;
  logic [CNT_W-1:0] load_count_d;

  assign op       = lga_op_e'(bus.in_op);
  assign in_ready = !bus.out_valid || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign fold     = acc_or_q ? (acc_q | bus.in_a) : (acc_q & bus.in_a);
  assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  assign bus.in_ready = in_ready;

  always_comb begin
    load_d       = 1'b0;
    load_data_d  = '0;
    load_count_d = '0;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (!lga_is_acc(op)) begin
          load_d       = 1'b1;
          load_data_d  = WIDTH'(lga_eval(op, LGA_MAX_W'(bus.in_a), LGA_MAX_W'(bus.in_b)));
          load_count_d = CNT_W'(1);
        end else if (bus.in_last) begin
          load_d       = 1'b1;
          load_data_d  = bus.in_a;
          load_count_d = CNT_W'(1);
        end
      end else if (bus.in_last) begin
        load_d       = 1'b1;
        load_data_d  = fold;
        load_count_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      acc_or_q <= 1'b0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (lga_is_acc(op) && !bus.in_last) begin
            acc_q    <= bus.in_a;
            cnt_q    <= CNT_W'(1);
            acc_or_q <= (op == LGA_ACC_OR);
            state_q  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_q <= fold;
          cnt_q <= cnt_next;
          if (bus.in_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  lga_out_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load_d),
    .load_data_i  (load_data_d),
    .load_count_i (load_count_d),
    .out_ready_i  (bus.out_ready),
`ifdef LGA_REDUCE_EN
    .out_red_o    (bus.out_red),
`endif
    .out_valid_o  (bus.out_valid),
    .out_data_o   (bus.out_data),
    .out_count_o  (bus.out_count)
  );

endmodule

// File: tb/tb_logic_gate_array.sv
module tb_logic_gate_array;
  localparam int W     = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_gate_array_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  logic_gate_array #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model: result register plus list of beats of an open burst
  logic          m_valid;
  logic [W-1:0]  m_data;
  int            m_count;
  bit            m_burst;
  int            m_bop;
  logic [W-1:0]  m_beats[$];

  function automatic logic [W-1:0] gate(int op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      0: return ~a;
      1: return a & b;
      2: return a | b;
      3: return ~(a & b);
      4: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [2:0] red(logic [W-1:0] d);
    return {^d, |d, &d};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_count = 0; m_burst = 0; m_bop = 0;
    m_beats.delete();
  endtask

  // Drives one cycle (called just after a falling edge), advances the model
  // across the rising edge and returns at the next falling edge.
  task automatic cyc(input bit v, input int op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit last, input bit ordy);
    bit acc, loaded;
    logic [W-1:0] r;
    bus.in_valid = v; bus.in_op = 3'(op); bus.in_a = a; bus.in_b = b;
    bus.in_last = last; bus.out_ready = ordy;
    #1;
    acc = v && (!m_valid || ordy);
    loaded = 0;
    if (acc) begin
      if (!m_burst) begin
        if (op < 6) begin
          m_data = gate(op, a, b); m_count = 1; loaded = 1;
        end else if (last) begin
          m_data = a; m_count = 1; loaded = 1;
        end else begin
          m_burst = 1; m_bop = op; m_beats.delete(); m_beats.push_back(a);
        end
      end else begin
        m_beats.push_back(a);
        if (last) begin
          r = m_beats[0];
          for (int i = 1; i < m_beats.size(); i++)
            r = (m_bop == 7) ? (r | m_beats[i]) : (r & m_beats[i]);
          m_data = r;
          m_count = (m_beats.size() > CMAX) ? CMAX : m_beats.size();
          loaded = 1; m_burst = 0;
        end
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (ordy) begin m_valid = 1'b0; m_data = '0; m_count = 0; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    total++; if (bus.out_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.out_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_gates();
    int ops[5] = '{1, 2, 5, 0, 2};
    logic [W-1:0] as[5] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    logic [W-1:0] bs[5] = '{4'b0110, 4'b0110, 4'b0110, 4'b1111, 4'b0101};
    logic [W-1:0] ex[5] = '{4'b0010, 4'b1110, 4'b1100, 4'b0101, 4'b1111};
    logic [2:0]   er[5] = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b011};
    for (int i = 0; i < 5; i++) begin
      cyc(1, ops[i], as[i], bs[i], 0, 1);
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== ex[i] || bus.out_count !== 2'd1) begin
        bad++; $display("FAIL gate_%0d got v=%b d=%b c=%0d exp v=1 d=%b c=1", i, bus.out_valid, bus.out_data, bus.out_count, ex[i]);
      end
`ifdef LGA_REDUCE_EN
      total++; if (bus.out_red !== er[i]) begin bad++; $display("FAIL gate_red_%0d got=%b exp=%b", i, bus.out_red, er[i]); end
`else
      if (er[i] == 3'b111) $display("unexpected reduce entry");
`endif
    end
    cyc(0, 0, 0, 0, 0, 1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL gate_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_acc_and();
    cyc(1, 6, 4'b1111, 4'b0000, 0, 1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_and_beat1 valid got=%b exp=0", bus.out_valid); end
    cyc(1, 6, 4'b1101, 4'b0000, 0, 1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_and_beat2 valid got=%b exp=0", bus.out_valid); end
    cyc(1, 6, 4'b0111, 4'b0000, 1, 1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0101 || bus.out_count !== 2'd3) begin
      bad++; $display("FAIL acc_and_result got v=%b d=%b c=%0d exp v=1 d=0101 c=3", bus.out_valid, bus.out_data, bus.out_count);
    end
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_acc_or_sat();
    logic [W-1:0] as[5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      // in_op is changed after the first beat; the latched op must stick
      cyc(1, (i == 0) ? 7 : 1, as[i], 4'b1000, (i == 4), 1);
      if (i < 4) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL acc_or_beat%0d valid got=%b exp=0", i, bus.out_valid); end
      end
    end
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0111 || bus.out_count !== 2'd3) begin
      bad++; $display("FAIL acc_or_sat got v=%b d=%b c=%0d exp v=1 d=0111 c=3", bus.out_valid, bus.out_data, bus.out_count);
    end
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    cyc(1, 4, 4'b1100, 4'b1010, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 4'(i + 5), 4'b1111, 0, 0);
      total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 4'b0001) begin
        bad++; $display("FAIL hold_%0d got rdy=%b v=%b d=%b exp rdy=0 v=1 d=0001", i, bus.in_ready, bus.out_valid, bus.out_data);
      end
    end
    cyc(1, 3, 4'b1100, 4'b1010, 0, 1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0111 || bus.out_count !== 2'd1) begin
      bad++; $display("FAIL no_bubble got v=%b d=%b c=%0d exp v=1 d=0111 c=1", bus.out_valid, bus.out_data, bus.out_count);
    end
    cyc(0, 0, 0, 0, 0, 1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_burst();
    cyc(1, 7, 4'b1000, 4'b0000, 0, 1);
    cyc(1, 7, 4'b0100, 4'b0000, 0, 1);
    do_reset();
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_count !== 2'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got v=%b d=%b c=%0d rdy=%b exp v=0 d=0 c=0 rdy=1", bus.out_valid, bus.out_data, bus.out_count, bus.in_ready);
    end
`ifdef LGA_REDUCE_EN
    total++; if (bus.out_red !== 3'b000) begin bad++; $display("FAIL mid_reset_red got=%b exp=000", bus.out_red); end
`endif
    cyc(1, 1, 4'b0011, 4'b0101, 0, 1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0001 || bus.out_count !== 2'd1) begin
      bad++; $display("FAIL after_reset got v=%b d=%b c=%0d exp v=1 d=0001 c=1", bus.out_valid, bus.out_data, bus.out_count);
    end
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit v, last, ordy;
    int op;
    for (int n = 0; n < 600; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      op   = $urandom_range(0, 7);
      last = ($urandom_range(0, 2) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      cyc(v, op, 4'($urandom), 4'($urandom), last, ordy);
      total++; if (bus.out_valid !== m_valid) begin
        bad++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, bus.out_valid, m_valid);
      end
      if (m_valid) begin
        total++; if (bus.out_data !== m_data || bus.out_count !== 2'(m_count)) begin
          bad++; $display("FAIL rand_data n=%0d got d=%b c=%0d exp d=%b c=%0d", n, bus.out_data, bus.out_count, m_data, m_count);
        end
`ifdef LGA_REDUCE_EN
        total++; if (bus.out_red !== red(m_data)) begin
          bad++; $display("FAIL rand_red n=%0d got=%b exp=%b", n, bus.out_red, red(m_data));
        end
`endif
      end
      total++; if (bus.in_ready !== (!m_valid || ordy)) begin
        bad++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, bus.in_ready, (!m_valid || ordy));
      end
    end
    // close any burst still open so the model and DUT end in the same place
    cyc(1, 7, 4'b0000, 4'b0000, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = '0; bus.in_b = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_gates();
    test_acc_and();
    test_acc_or_sat();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
